// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants and types.
//   state_t      : game state encoding (IDLE/FLY/DEAD), also the value seen on the
//                  2-bit state output of bird_physics.
//   SCREEN_*     : visible raster size.
//   BIRD_*       : bird sprite placement, shared with the pipe and collision blocks.
//   physics      : gravity, flap impulse, terminal velocity, restart hold time.
//   *_W          : datapath widths used by the physics block.
package flappy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FLY  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;

   localparam int BIRD_X    = 200;
   localparam int BIRD_SIZE = 16;
   localparam int START_Y   = 232;

   localparam int GRAVITY   = 1;
   localparam int FLAP_VEL  = -8;
   localparam int MAX_FALL  = 10;
   localparam int DEAD_HOLD = 60;

   localparam int Y_W   = 10;   // bird row
   localparam int VEL_W = 8;    // signed velocity
   localparam int POS_W = 12;   // signed position sum, wide enough for 1023 + 127

endpackage

// File: rtl/edge_detect_rise.sv
// One-bit rising-edge detector.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, loads the history register with RST_VAL
//   i_sig   : level input, already synchronous to i_clk
//   o_pulse : high for the cycle in which i_sig is 1 and was 0 on the previous cycle
// The pulse is combinational from i_sig so the consumer can act in the same cycle
// the edge arrives; only the history bit is registered.
module edge_detect_rise #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_pulse
);

   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_prev <= RST_VAL;
      else       r_prev <= i_sig;
   end

   assign o_pulse = i_sig & ~r_prev;

endmodule

// File: rtl/bird_physics.sv
// Flappy Bird vertical physics and game-state machine.
//   clk25     : 25 MHz pixel clock (same as the sync generator)
//   rst       : synchronous active-high reset
//   vs        : vertical sync, low during rows 0..1
//   valid     : visible-area flag
//   xPos/yPos : visible column/row from the sync generator
//   flap      : button level, synchronous to clk25
//   collide   : pipe-hit pulse or level
//   frameTick : one-cycle pulse on the vs rising edge; all physics happens here
//   birdY     : bird top row
//   state     : 0=IDLE 1=FLY 2=DEAD
//   birdPixel : bird covers the pixel presented on the previous cycle
module bird_physics
   import flappy_pkg::*;
(
   input  logic        clk25,
   input  logic        rst,
   input  logic        vs,
   input  logic        valid,
   input  logic [31:0] xPos,
   input  logic [31:0] yPos,
   input  logic        flap,
   input  logic        collide,
   output logic        frameTick,
   output logic [9:0]  birdY,
   output logic [1:0]  state,
   output logic        birdPixel
);

   localparam int CNT_W = $clog2(DEAD_HOLD + 1);

   localparam logic        [Y_W-1:0]   L_START_Y   = Y_W'(START_Y);
   localparam logic        [Y_W-1:0]   L_FLOOR_Y   = Y_W'(SCREEN_H - BIRD_SIZE);
   localparam logic signed [POS_W-1:0] L_FLOOR_POS = POS_W'(SCREEN_H - BIRD_SIZE);
   localparam logic signed [VEL_W-1:0] L_FLAP_VEL  = VEL_W'(FLAP_VEL);
   localparam logic signed [VEL_W-1:0] L_GRAVITY   = VEL_W'(GRAVITY);
   localparam logic signed [VEL_W-1:0] L_MAX_FALL  = VEL_W'(MAX_FALL);
   localparam logic        [CNT_W-1:0] L_DEAD_HOLD = CNT_W'(DEAD_HOLD);
   localparam logic        [10:0]      L_BIRD_X0   = 11'(BIRD_X);
   localparam logic        [10:0]      L_BIRD_X1   = 11'(BIRD_X + BIRD_SIZE);
   localparam logic        [10:0]      L_BIRD_SZ   = 11'(BIRD_SIZE);

   function automatic logic signed [VEL_W-1:0] sat_fall(input logic signed [VEL_W-1:0] v);
      logic signed [VEL_W-1:0] s;
      s = v + L_GRAVITY;
      return (s > L_MAX_FALL) ? L_MAX_FALL : s;
   endfunction

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
      return (c >= L_DEAD_HOLD) ? L_DEAD_HOLD : c + 1'b1;
   endfunction

   state_t                  r_state, w_stateNext;
   logic        [Y_W-1:0]   r_birdY, w_birdYNext;
   logic signed [VEL_W-1:0] r_vel, w_velNext, w_velBase;
   logic        [CNT_W-1:0] r_deadCnt, w_deadCntNext;
   logic                    r_flapPending, r_hitPending, r_birdPixel_p1;
   logic                    w_tick, w_flapEdge, w_flapNow, w_hitNow, w_floorHit;
   logic signed [POS_W-1:0] w_nextY;
   logic        [10:0]      w_x11, w_y11, w_yTop, w_yBot;
   logic                    w_pixHit;
   logic                    w_unused_hi;

   // vs history resets high so a reset while vs is already high cannot fake a tick
   edge_detect_rise #(.RST_VAL(1'b1)) u_vs_edge (
      .i_clk(clk25), .i_rst(rst), .i_sig(vs), .o_pulse(w_tick)
   );

   edge_detect_rise #(.RST_VAL(1'b0)) u_flap_edge (
      .i_clk(clk25), .i_rst(rst), .i_sig(flap), .o_pulse(w_flapEdge)
   );

   // an edge arriving on the tick cycle itself still counts for that tick
   assign w_flapNow  = r_flapPending | w_flapEdge;
   assign w_hitNow   = r_hitPending | collide;
   assign w_nextY    = {2'b00, r_birdY} + {{(POS_W-VEL_W){r_vel[VEL_W-1]}}, r_vel};
   assign w_floorHit = (w_nextY >= L_FLOOR_POS);

   always_ff @(posedge clk25) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      if (w_tick) begin
         case (r_state)
            ST_IDLE: if (w_flapNow) w_stateNext = ST_FLY;
            ST_FLY:  if (w_hitNow || w_floorHit) w_stateNext = ST_DEAD;
            ST_DEAD: if (r_deadCnt == L_DEAD_HOLD && w_flapNow) w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_birdYNext   = r_birdY;
      w_velNext     = r_vel;
      w_velBase     = r_vel;
      w_deadCntNext = (r_state == ST_DEAD) ? r_deadCnt : '0;
      if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               w_birdYNext = L_START_Y;
               w_velNext   = w_flapNow ? L_FLAP_VEL : '0;
            end
            ST_FLY: begin
               if (w_hitNow) begin
                  w_velNext = '0;
               end else if (w_floorHit) begin
                  w_birdYNext = L_FLOOR_Y;
                  w_velNext   = '0;
               end else begin
                  // ceiling clamp zeroes velocity before gravity/flap is applied
                  if (w_nextY[POS_W-1]) begin
                     w_birdYNext = '0;
                     w_velBase   = '0;
                  end else begin
                     w_birdYNext = w_nextY[Y_W-1:0];
                  end
                  w_velNext = w_flapNow ? L_FLAP_VEL : sat_fall(w_velBase);
               end
            end
            ST_DEAD: begin
               if (r_deadCnt == L_DEAD_HOLD && w_flapNow) begin
                  w_birdYNext   = L_START_Y;
                  w_velNext     = '0;
                  w_deadCntNext = '0;
               end else begin
                  w_deadCntNext = sat_cnt(r_deadCnt);
               end
            end
            default: ;
         endcase
      end
   end

   // pixel compare uses the low 11 bits only; out-of-area wrap values have valid=0
   assign w_x11    = xPos[10:0];
   assign w_y11    = yPos[10:0];
   assign w_yTop   = {1'b0, r_birdY};
   assign w_yBot   = w_yTop + L_BIRD_SZ;
   assign w_pixHit = valid && (w_x11 >= L_BIRD_X0) && (w_x11 < L_BIRD_X1) &&
                     (w_y11 >= w_yTop) && (w_y11 < w_yBot);
   assign w_unused_hi = ^{xPos[31:11], yPos[31:11]};

   always_ff @(posedge clk25) begin
      if (rst) begin
         r_birdY        <= L_START_Y;
         r_vel          <= '0;
         r_deadCnt      <= '0;
         r_flapPending  <= 1'b0;
         r_hitPending   <= 1'b0;
         r_birdPixel_p1 <= 1'b0;
      end else begin
         r_birdY        <= w_birdYNext;
         r_vel          <= w_velNext;
         r_deadCnt      <= w_deadCntNext;
         r_flapPending  <= w_tick ? 1'b0 : w_flapNow;
         r_hitPending   <= w_tick ? 1'b0 : w_hitNow;
         // pixel stage p1: one cycle behind xPos/yPos/valid
         r_birdPixel_p1 <= w_pixHit;
      end
   end

   assign frameTick = w_tick;
   assign birdY     = r_birdY;
   assign state     = r_state;
   assign birdPixel = r_birdPixel_p1;

endmodule

// File: tb/tb_bird_physics.sv
module tb_bird_physics;

   logic        clk25 = 1'b0;
   logic        rst, vs, valid, flap, collide;
   logic [31:0] xPos, yPos;
   logic        frameTick, birdPixel;
   logic [9:0]  birdY;
   logic [1:0]  state;

   int n_checks = 0;
   int n_err    = 0;
   int tick_cnt = 0;
   int pix_cnt  = 0;
   bit chk_en   = 0;
   bit scan_en  = 0;

   // reference model state (plain integers)
   int m_y, m_vel, m_st, m_cnt;
   bit m_vsPrev, m_flapPrev, m_fp, m_hp, m_pix;

   bird_physics dut (
      .clk25(clk25), .rst(rst), .vs(vs), .valid(valid), .xPos(xPos), .yPos(yPos),
      .flap(flap), .collide(collide), .frameTick(frameTick), .birdY(birdY),
      .state(state), .birdPixel(birdPixel)
   );

   always #20 clk25 = ~clk25;

   initial begin
      #8000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: game rules in integer arithmetic, advanced at each clock edge
   always @(posedge clk25) begin : model
      bit tk, fn, hn;
      int ny, base, x11, y11;
      if (rst) begin
         m_st = 0; m_y = 232; m_vel = 0; m_cnt = 0;
         m_fp = 0; m_hp = 0; m_pix = 0; m_vsPrev = 1; m_flapPrev = 0;
      end else begin
         x11 = int'(xPos[10:0]);
         y11 = int'(yPos[10:0]);
         m_pix = valid && x11 >= 200 && x11 < 216 && y11 >= m_y && y11 < m_y + 16;
         tk = vs && !m_vsPrev;
         fn = m_fp || (flap && !m_flapPrev);
         hn = m_hp || collide;
         if (tk) begin
            if (m_st == 0) begin
               m_y = 232;
               if (fn) begin m_vel = -8; m_st = 1; end
               else m_vel = 0;
            end else if (m_st == 1) begin
               ny = m_y + m_vel;
               if (hn) begin
                  m_st = 2; m_vel = 0;
               end else if (ny >= 464) begin
                  m_y = 464; m_vel = 0; m_st = 2;
               end else begin
                  if (ny < 0) begin m_y = 0; base = 0; end
                  else begin m_y = ny; base = m_vel; end
                  m_vel = fn ? -8 : ((base + 1 > 10) ? 10 : base + 1);
               end
            end else begin
               if (m_cnt == 60 && fn) begin
                  m_st = 0; m_y = 232; m_vel = 0; m_cnt = 0;
               end else if (m_cnt < 60) begin
                  m_cnt = m_cnt + 1;
               end
            end
         end
         if (m_st != 2) m_cnt = 0;
         m_fp = tk ? 1'b0 : fn;
         m_hp = tk ? 1'b0 : hn;
         m_vsPrev = vs;
         m_flapPrev = flap;
      end
   end

   // compare process, half a clock after each active edge
   always @(negedge clk25) begin
      if (chk_en) begin
         if (!rst) begin
            check("frameTick", frameTick, (vs && !m_vsPrev) ? 1 : 0);
            if (frameTick) tick_cnt++;
         end
         check("birdY", birdY, m_y);
         check("state", state, m_st);
         check("birdPixel", birdPixel, m_pix);
         if (scan_en && birdPixel) pix_cnt++;
      end
   end

   task automatic tick_clk();
      @(posedge clk25);
      #5;
   endtask

   task automatic rand_pix();
      if ($urandom_range(0, 3) == 0) begin
         valid = 1'b0;
         xPos  = $urandom;
         yPos  = $urandom;
      end else begin
         valid = 1'b1;
         xPos  = 32'(192 + int'($urandom_range(0, 31)));
         yPos  = 32'(m_y - 4 + int'($urandom_range(0, 23)));
      end
   endtask

   // one compressed frame: vs low for cycles 0..1, tick lands on cycle 2
   task automatic run_frame(input int len, input int flap_at, input int col_at, input int rst_at);
      for (int c = 0; c < len; c++) begin
         vs      = (c >= 2);
         flap    = (flap_at >= 0) && (c == flap_at || c == flap_at + 1);
         collide = (c == col_at);
         rst     = (c == rst_at);
         rand_pix();
         tick_clk();
      end
      rst = 1'b0; flap = 1'b0; collide = 1'b0;
   endtask

   int exp_y[4] = '{224, 217, 211, 206};

   initial begin
      int len, fa, ca;
      rst = 1'b1; vs = 1'b1; valid = 1'b0; flap = 1'b0; collide = 1'b0;
      xPos = '0; yPos = '0;
      tick_clk();
      chk_en = 1;
      tick_clk();
      tick_clk();
      rst = 1'b0;
      check("reset_state", state, 0);
      check("reset_birdY", birdY, 232);
      check("reset_pixel", birdPixel, 0);

      // idle frames
      tick_cnt = 0;
      repeat (3) run_frame(30, -1, -1, -1);
      check("idle_ticks", tick_cnt, 3);
      check("idle_state", state, 0);
      check("idle_birdY", birdY, 232);

      // launch and ballistic flight
      run_frame(30, 10, -1, -1);
      run_frame(30, -1, -1, -1);
      check("launch_state", state, 1);
      check("launch_birdY", birdY, 232);
      for (int k = 0; k < 4; k++) begin
         run_frame(30, -1, -1, -1);
         check("flight_birdY", birdY, exp_y[k]);
      end
      repeat (45) run_frame(30, -1, -1, -1);
      check("floor_state", state, 2);
      check("floor_birdY", birdY, 464);
      repeat (3) run_frame(30, -1, -1, -1);
      check("floor_frozen", birdY, 464);
      repeat (65) run_frame(30, -1, -1, -1);
      run_frame(30, 10, -1, -1);
      run_frame(30, -1, -1, -1);
      check("restart_state", state, 0);
      check("restart_birdY", birdY, 232);

      // flap every frame: climb to the ceiling and stay clamped
      repeat (35) run_frame(30, 10, -1, -1);
      check("ceiling_birdY", birdY, 0);
      check("ceiling_state", state, 1);

      // collision, restart hold window
      run_frame(30, -1, 15, -1);
      run_frame(30, -1, -1, -1);
      check("collide_state", state, 2);
      for (int j = 1; j <= 61; j++) begin
         run_frame(30, (j == 29 || j == 59 || j == 60) ? 10 : -1, -1, -1);
         if (j == 30) check("dead_flap30_ignored", state, 2);
         if (j == 60) check("dead_flap60_ignored", state, 2);
      end
      check("dead_restart_state", state, 0);
      check("dead_restart_birdY", birdY, 232);

      // randomized play, including same-cycle edges and a mid-frame reset
      for (int f = 0; f < 150; f++) begin
         len = 20 + int'($urandom_range(0, 20));
         fa  = ($urandom_range(0, 9) < 6) ? int'($urandom_range(2, len - 3)) : -1;
         ca  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, len - 1)) : -1;
         run_frame(len, fa, ca, (f == 75) ? 10 : -1);
      end

      // full scan of the bird neighbourhood with birdY at the start row
      rst = 1'b1; vs = 1'b1; valid = 1'b0; flap = 1'b0; collide = 1'b0;
      tick_clk();
      tick_clk();
      rst = 1'b0;
      tick_clk();
      check("scan_birdY", birdY, 232);
      pix_cnt = 0;
      scan_en = 1;
      for (int y = 224; y < 256; y++) begin
         for (int x = 192; x < 224; x++) begin
            valid = 1'b1;
            xPos  = 32'(x);
            yPos  = 32'(y);
            tick_clk();
         end
      end
      valid = 1'b0;
      tick_clk();
      tick_clk();
      scan_en = 0;
      check("scan_pixel_count", pix_cnt, 256);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Downstream consumer of the VGA sync generator's timing outputs (vs, valid, xPos, yPos).
- Derives a one-per-frame tick from vs and runs the Flappy Bird vertical physics: gravity, flap impulse, floor/ceiling clamp and a game-state FSM (IDLE/FLY/DEAD).
- Emits the bird's current row plus a registered per-pixel "bird here" flag for the colour mixer.

Parameters:
SCREEN_H, 480, visible rows
BIRD_X, 200, left column of bird sprite (fixed)
BIRD_SIZE, 16, bird square edge in pixels
START_Y, 232, bird row in IDLE / after restart
GRAVITY, 1, velocity increment per frame (rows/frame)
FLAP_VEL, -8, signed velocity loaded on flap
MAX_FALL, 10, maximum downward velocity
DEAD_HOLD, 60, frames DEAD must last before a flap can restart

Ports:
clk25  in  1  25 MHz pixel clock, same clock as the sync generator
rst  in  1  synchronous, active-high reset
vs  in  1  vertical sync from sync generator (low during rows 0..1)
valid  in  1  visible-area flag
xPos  in  32  visible column (xCounter-144)
yPos  in  32  visible row (yCounter-35)
flap  in  1  button level, already synchronised to clk25
collide  in  1  pipe-hit pulse/level from pipe block
frameTick  out  1  one-cycle pulse per frame
birdY  out  10  bird top row, unsigned
state  out  2  0=IDLE 1=FLY 2=DEAD
birdPixel  out  1  bird covers current pixel, 1-cycle latency

Behaviour:
- Reset (rst=1 at posedge clk25): state=IDLE, birdY=START_Y, vel=0, frameTick=0, birdPixel=0, flapPending=0, hitPending=0, deadCnt=0, vsPrev=1.
- frameTick: vsPrev<=vs each cycle; frameTick=1 for exactly one cycle when vsPrev=0 and vs=1 (line 2 of frame). All physics updates occur only on frameTick cycles.
- Flap edge: rising edge of flap (registered prev) sets flapPending. Cleared on any frameTick. An edge in the same cycle as frameTick counts for that tick.
- collide=1 in any cycle sets hitPending; cleared on frameTick. A collide in the same cycle as frameTick counts.
- vel is signed 8-bit. Position math uses a signed 12-bit sum nextY = birdY + vel (old vel).
- IDLE on tick: birdY=START_Y. If flap is pending: vel=FLAP_VEL and state goes to FLY. Otherwise vel=0.
- FLY on tick, first matching case wins:
  - hitPending: state goes to DEAD, position frozen, vel=0.
  - nextY >= SCREEN_H-BIRD_SIZE: birdY=SCREEN_H-BIRD_SIZE, vel=0, state goes to DEAD.
  - nextY < 0: birdY=0, vel=0, no death (ceiling clamp).
  - Otherwise: birdY=nextY.
  - In both of the last two cases, vel then becomes FLAP_VEL if a flap is pending, else min(vel+GRAVITY, MAX_FALL).
- DEAD on tick:
  - birdY and vel frozen.
  - deadCnt increments, saturating at DEAD_HOLD.
  - If deadCnt==DEAD_HOLD and a flap is pending: state goes to IDLE, birdY=START_Y, vel=0, deadCnt=0. The flap is consumed and does not start flight.
  - deadCnt is cleared whenever state is not DEAD.
- birdPixel is registered. On the next cycle it equals valid AND BIRD_X<=xPos<BIRD_X+BIRD_SIZE AND birdY<=yPos<birdY+BIRD_SIZE. Compare xPos/yPos as 11-bit after checking valid, so negative wrap values are ignored. Consumers delay hs/vs/valid by 1 to align.
- birdY changes only on frameTick (during rows 2..34, i.e. blanking), so no tearing.
- Reset mid-frame: everything returns to reset values next cycle. The first frameTick occurs at the next vs rising edge.

Decomposition:
- Shared package flappy_pkg holds:
  - State encodings ST_IDLE/ST_FLY/ST_DEAD.
  - Screen constants SCREEN_W=640, SCREEN_H=480.
  - Bird geometry constants, shared with the pipe and collision blocks.
- One natural sub-module: edge_detect_rise (1-bit registered rising-edge pulse), instantiated for vs and flap.

Test Plan:
- Reset, then run 3 frames with no flap → state=0, birdY=232, exactly one frameTick per 420000 clk25 cycles.
- Flap pulse in frame 1 → next tick: state=1, birdY=232, vel=-8. Following ticks birdY=224, 217, 211, 206.
- No further flaps after launch → vel saturates at 10. Once nextY>=464: birdY=464, state=2. Later ticks leave birdY unchanged.
- Flap every tick from start → birdY decreases until nextY<0, then clamps to 0 and vel resets. State stays 1 (no ceiling death).
- In FLY, collide for 1 cycle mid-frame → next tick state=2. Flap at DEAD tick 30 is ignored. Flap after tick 60 → state=0, birdY=232.
- With birdY=232, scan the frame → birdPixel high exactly for xPos 200..215, yPos 232..247, delayed by one cycle; 256 pixels per frame.
